// File: rtl/prefix_adder_pkg.sv
// Shared types and depth helpers for the pipelined Kogge-Stone adder.
package prefix_adder_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  // Combine distance of prefix level k (levels are numbered from 1).
  function automatic int lvl_dist(input int k);
    return 32'sd1 << (k - 32'sd1);
  endfunction

  function automatic int levels_of(input int width);
    return $clog2(width);
  endfunction

  function automatic int latency_of(input int width);
    return $clog2(width) + 32'sd2;
  endfunction

endpackage

// File: rtl/prefix_adder_pipe_if.sv
// Operand/result handshake bundle between issue logic, the adder and the consumer.
interface prefix_adder_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/prefix_level.sv
// One combinational Kogge-Stone combine row at a fixed distance.
module prefix_level
  import prefix_adder_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DIST     = 1,
  parameter bit GEN_ONLY = 1'b0
) (
  input  pg_t [WIDTH-1:0] pg_in,
  output pg_t [WIDTH-1:0] pg_out
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= DIST) begin : g_cell
      assign pg_out[i].g = pg_in[i].g | (pg_in[i].p & pg_in[i-DIST].g);
      // Nothing downstream of the final row consumes group propagate.
      if (GEN_ONLY) begin : g_gen
        assign pg_out[i].p = 1'b0;
      end else begin : g_pg
        assign pg_out[i].p = pg_in[i].p & pg_in[i-DIST].p;
      end
    end else begin : g_pass
      assign pg_out[i] = pg_in[i];
    end
  end

endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder: PG capture, one register per prefix level, registered sum.
// The whole pipe advances or holds together on a single stall enable.
module prefix_adder_pipe
  import prefix_adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  prefix_adder_pipe_if.slave bus
);

  localparam int LEVELS = levels_of(WIDTH);

  logic                   en_s;
  pg_t [WIDTH-1:0]        pg0_s;
  pg_t [WIDTH-1:0]        level_s [1:LEVELS];
  pg_t [WIDTH-1:0]        stage_r [0:LEVELS];
  logic [WIDTH-1:0]       p0_r    [0:LEVELS];
  logic [LEVELS:0]        cin_r;
  logic [LEVELS:0]        valid_r;
  logic [WIDTH-1:0]       g_last_s;
  logic [WIDTH-1:0]       carry_s;
  logic [WIDTH-1:0]       sum_r;
  logic                   out_valid_r;
  logic                   cout_r;
  logic                   ovf_r;

  assign en_s          = ~out_valid_r | bus.out_ready;
  assign bus.in_ready  = en_s;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;

  // Bitwise generate/propagate, with the carry-in absorbed into bit 0's generate.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      pg0_s[i].g = bus.a[i] & bus.b[i];
      pg0_s[i].p = bus.a[i] ^ bus.b[i];
    end
    pg0_s[0].g = (bus.a[0] & bus.b[0]) | ((bus.a[0] ^ bus.b[0]) & bus.cin);
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    prefix_level #(
      .WIDTH    (WIDTH),
      .DIST     (lvl_dist(k)),
      .GEN_ONLY (k == LEVELS)
    ) u_level (
      .pg_in  (stage_r[k-1]),
      .pg_out (level_s[k])
    );
  end

  // Carry into bit i is the full group generate of bits i-1..0.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      g_last_s[i] = stage_r[LEVELS][i].g;
    end
    carry_s = {g_last_s[WIDTH-2:0], cin_r[LEVELS]};
  end

  // Pipeline registers: all stages shift together when en_s, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r     <= '0;
      cin_r       <= '0;
      out_valid_r <= 1'b0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      for (int k = 0; k <= LEVELS; k++) begin
        stage_r[k] <= '0;
        p0_r[k]    <= '0;
      end
    end else if (en_s) begin
      valid_r    <= {valid_r[LEVELS-1:0], bus.in_valid};
      cin_r      <= {cin_r[LEVELS-1:0], bus.cin};
      stage_r[0] <= pg0_s;
      p0_r[0]    <= bus.a ^ bus.b;
      for (int k = 1; k <= LEVELS; k++) begin
        stage_r[k] <= level_s[k];
        p0_r[k]    <= p0_r[k-1];
      end
      out_valid_r <= valid_r[LEVELS];
      sum_r       <= p0_r[LEVELS] ^ carry_s;
      cout_r      <= g_last_s[WIDTH-1];
      ovf_r       <= g_last_s[WIDTH-2] ^ g_last_s[WIDTH-1];
    end
  end

endmodule
